seg7_multi_digit_drv: RTL and testbench

Parametrised multi-digit seven-segment driver, successor to the single-digit BCD decoder.
- Latches an N-digit hex value on a load strobe and decodes all 16 hex codes, with no undefined patterns.
- Applies per-digit enable and leading-zero blanking.
- Drives both a static per-digit segment bus and a time-multiplexed scan interface (shared segment lines plus one-hot digit select).
- Sits between FIFO status/count logic and the board's display pins.

---
 rtl/seg7_pkg.sv | 12 +
 rtl/seg7_hex_decode.sv | 12 +
 rtl/seg7_multi_digit_drv.sv | 100 ++++++++++
 tb/tb_seg7_multi_digit_drv.sv | 116 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment type, active-high hex pattern table and polarity helper
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam seg_t SEG_BLANK = 7'h00;
  function automatic seg_t apply_polarity(input seg_t s, input bit active_low);
    return active_low ? ~s : s;
  endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to seven-segment pattern with blanking and output polarity
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  output seg_t       seg
);
  assign seg = apply_polarity(blank ? SEG_BLANK : SEG_TABLE[nib], ACTIVE_LOW != 0);
endmodule

// File: rtl/seg7_multi_digit_drv.sv
// seg7_multi_digit_drv: N-digit hex display driver, static and scanned outputs; SEG7_BLINK_EN adds per-digit blink
module seg7_multi_digit_drv
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int SCAN_DIV   = 50000
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV  = 25_000_000
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lz_blank_i,
  input  logic                    load_i,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_i,
`endif
  output logic [7*NUM_DIGITS-1:0] seg_o,
  output seg_t                    scan_seg_o,
  output logic [NUM_DIGITS-1:0]   scan_an_o
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam seg_t OFF_SEG = apply_polarity(SEG_BLANK, ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   en_q, blank;
  logic                    lz_q, z;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx, idx_next;
  seg_t                    scan_d;
  logic                    phase;
`ifdef SEG7_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [BW-1:0]         bcnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      blink_q <= '0;
      bcnt    <= '0;
      phase   <= 1'b0;
    end else begin
      if (load_i) blink_q <= blink_i;
      bcnt  <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
      phase <= bcnt == BW'(BLINK_DIV - 1) ? ~phase : phase;
    end
`else
  assign phase = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      val_q <= '0;
      en_q  <= '0;
      lz_q  <= 1'b0;
    end else if (load_i) begin
      val_q <= value_i;
      en_q  <= digit_en_i;
      lz_q  <= lz_blank_i;
    end
  // z tracks "this digit and every higher digit are zero" while walking down from the MSD
  always_comb begin
    z = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z & (val_q[4*k +: 4] == 4'h0);
      blank[k] = ~en_q[k] | (lz_q & z & (k != 0)) |
`ifdef SEG7_BLINK_EN
                 (phase & blink_q[k]);
`else
                 phase;
`endif
    end
  end
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    seg7_hex_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
      .nib(val_q[4*g +: 4]), .blank(blank[g]), .seg(seg_d[7*g +: 7]));
  end
  assign idx_next = cnt == CW'(SCAN_DIV - 1) ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1) : idx;
  // scan outputs are built from idx_next so select and segments register on the same edge
  seg7_hex_decode #(.ACTIVE_LOW(ACTIVE_LOW)) u_scan_dec (
    .nib(val_q[4*idx_next +: 4]), .blank(blank[idx_next]), .seg(scan_d));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      seg_o      <= {NUM_DIGITS{OFF_SEG}};
      scan_seg_o <= OFF_SEG;
      scan_an_o  <= ACTIVE_LOW != 0 ? ~ONE : ONE;
    end else begin
      cnt        <= cnt == CW'(SCAN_DIV - 1) ? '0 : cnt + 1'b1;
      idx        <= idx_next;
      seg_o      <= seg_d;
      scan_seg_o <= scan_d;
      scan_an_o  <= ACTIVE_LOW != 0 ? ~(ONE << idx_next) : ONE << idx_next;
    end
endmodule

// File: tb/tb_seg7_multi_digit_drv.sv
// tb_seg7_multi_digit_drv: scoreboard bench, directed spec vectors plus randomized loads against a digit-level model
module tb_seg7_multi_digit_drv;
  localparam int N = 4;
  localparam int DIV = 4;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  localparam logic [6:0] SWEEP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct { int cyc; logic [27:0] seg; } exp_t;
  logic clk = 0, rst = 1, lz_blank_i = 0, load_i = 0;
  logic [15:0] value_i = '0;
  logic [3:0] digit_en_i = '0, scan_an_o;
  logic [27:0] seg_o, cur_exp = '1;
  logic [6:0] scan_seg_o;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  seg7_multi_digit_drv #(.NUM_DIGITS(N), .ACTIVE_LOW(1), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .digit_en_i(digit_en_i),
    .lz_blank_i(lz_blank_i), .load_i(load_i), .seg_o(seg_o),
    .scan_seg_o(scan_seg_o), .scan_an_o(scan_an_o));
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;
  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask
  function automatic logic [27:0] model(input logic [15:0] v, input logic [3:0] e, input logic l);
    logic [27:0] r;
    logic [3:0] d;
    bit lead = 1;
    for (int k = N - 1; k >= 0; k--) begin
      d = v[4*k +: 4];
      if (d != 0) lead = 0;
      r[7*k +: 7] = (!e[k] || (l && lead && k != 0)) ? 7'h7F : ~HEX[d];
    end
    return r;
  endfunction
  // monitor: adopt the next expected static image when its cycle arrives, check every cycle
  always @(negedge clk) begin
    int i;
    if (rst) begin
      q.delete();
      cur_exp = '1;
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc) cur_exp = q.pop_front().seg;
      i = (cyc / DIV) % N;
      chk("seg_o", seg_o, cur_exp);
      chk("scan_an_o", {24'd0, scan_an_o}, {24'd0, ~(4'b1 << i)});
      chk("scan_seg_o", {21'd0, scan_seg_o}, {21'd0, cur_exp[7*i +: 7]});
    end
  end
  task automatic ld(input logic [15:0] v, input logic [3:0] e, input logic l, input logic [27:0] want);
    value_i = v;
    digit_en_i = e;
    lz_blank_i = l;
    load_i = 1;
    q.push_back('{cyc + 2, want});
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    load_i = 0;
    repeat (n) @(negedge clk);
  endtask
  initial begin
    logic [15:0] v;
    repeat (3) @(negedge clk);
    rst = 0;
    idle(6);
    ld(16'h00A5, 4'hF, 1, {7'h7F, 7'h7F, 7'h08, 7'h12});
    idle(3);
    ld(16'h00A5, 4'hF, 0, {7'h40, 7'h40, 7'h08, 7'h12});
    idle(3);
    for (int i = 0; i < 16; i++) begin
      ld(16'(i), 4'hF, 0, {7'h40, 7'h40, 7'h40, SWEEP[i]});
      idle(2);
    end
    ld(16'h0000, 4'hF, 1, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    idle(3);
    ld(16'h1234, 4'b1011, 0, {7'h79, 7'h7F, 7'h30, 7'h19});
    idle(3);
    ld(16'h1234, 4'hF, 0, {7'h79, 7'h24, 7'h30, 7'h19});
    idle(20);
    for (int i = 0; i < 300; i++) begin
      v = 16'($urandom);
      for (int k = 0; k < N; k++) if ($urandom_range(0, 2) == 0) v[4*k +: 4] = 4'h0;
      ld(v, 4'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 4'hF : 4'h0)), 1'($urandom), '0);
      q[q.size() - 1].seg = model(value_i, digit_en_i, lz_blank_i);
      if ($urandom_range(0, 3) != 0) idle($urandom_range(0, 6));
    end
    idle(5);
    #2 rst = 1;
    #1;
    chk("rst seg_o", seg_o, '1);
    chk("rst scan_an_o", {24'd0, scan_an_o}, {24'd0, 4'b1110});
    chk("rst scan_seg_o", {21'd0, scan_seg_o}, {21'd0, 7'h7F});
    repeat (2) @(negedge clk);
    rst = 0;
    idle(10);
    ld(16'hBEEF, 4'hF, 1, model(16'hBEEF, 4'hF, 1));
    idle(9);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected images never reached", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
